// File: rtl/apb_des_ctrl.sv
// APB slave front-end for the DES core: decodes register accesses into one-cycle
// command pulses, tracks key loading, and inserts a wait state on output-FIFO reads.
module apb_des_ctrl #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 5,
  parameter int IN_DEPTH  = 24,
  parameter int KEY_WORDS = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [CNT_W-1:0]  data_in_cnt,
  input  logic [CNT_W-1:0]  data_out_cnt,
  input  logic [DATA_W-1:0] data_out,
  output logic [2:0]        mode,
  output logic [DATA_W-1:0] wdata_out,
  output logic              key_loaded
);

  localparam int KEY_W = $clog2(KEY_WORDS);
  localparam logic [KEY_W-1:0] KEY_LAST = KEY_W'(KEY_WORDS - 1);
  localparam logic [KEY_W-1:0] KEY_HALF = KEY_W'(KEY_WORDS / 2);
  localparam logic [CNT_W:0]   IN_FULL  = (CNT_W + 1)'(IN_DEPTH);

  localparam logic [2:0] MODE_NONE   = 3'd0;
  localparam logic [2:0] MODE_ENC    = 3'd1;
  localparam logic [2:0] MODE_DEC    = 3'd2;
  localparam logic [2:0] MODE_KEY_LO = 3'd3;
  localparam logic [2:0] MODE_KEY_HI = 3'd4;
  localparam logic [2:0] MODE_SRST   = 3'd5;
  localparam logic [2:0] MODE_POP    = 3'd6;

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACCESS} state_t;

  state_t              state_reg, state_next;
  logic                err_reg, err_next;
  logic [2:0]          mode_reg, mode_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [KEY_W-1:0]    key_cnt_reg, key_cnt_next;
  logic                key_loaded_reg, key_loaded_next;
  logic                setup;
  logic                setup_err;
  logic                rd_pop_ok;
  logic                done;

  assign setup = (state_reg == IDLE) && PSEL && !PENABLE;

  // Error classification uses the setup-cycle view of the FIFO levels and key state.
  always_comb begin
    setup_err = 1'b0;
    if (PWRITE) begin
      if (PADDR[2])
        setup_err = 1'b1;
      else if ((PADDR[2:1] == 2'b00) &&
               (({1'b0, data_in_cnt} >= IN_FULL) || !key_loaded_reg))
        setup_err = 1'b1;
    end else begin
      if (!PADDR[2])
        setup_err = 1'b1;
      else if ((PADDR == 3'd4) && (data_out_cnt == '0))
        setup_err = 1'b1;
    end
  end

  assign rd_pop_ok = !PWRITE && (PADDR == 3'd4) && !setup_err;

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (setup) begin
          err_next   = setup_err;
          state_next = rd_pop_ok ? RD_WAIT : ACCESS;
        end
      end
      RD_WAIT: state_next = PSEL ? ACCESS : IDLE;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign PREADY  = (state_reg == ACCESS);
  assign PSLVERR = PREADY && err_reg;
  assign done    = PREADY && PSEL && PENABLE && !err_reg;

  always_comb begin
    PRDATA = '0;
    if ((state_reg == ACCESS) && !err_reg && !PWRITE) begin
      case (PADDR)
        3'd4:    PRDATA = data_out;
        3'd5:    PRDATA[CNT_W-1:0] = data_in_cnt;
        3'd6:    PRDATA[CNT_W-1:0] = data_out_cnt;
        3'd7:    PRDATA[KEY_W:0] = {key_cnt_reg, key_loaded_reg};
        default: PRDATA = '0;
      endcase
    end
  end

  always_comb begin
    mode_next       = MODE_NONE;
    wdata_next      = wdata_reg;
    key_cnt_next    = key_cnt_reg;
    key_loaded_next = key_loaded_reg;
    if (done) begin
      if (PWRITE) begin
        wdata_next = PWDATA;
        case (PADDR)
          3'd0: mode_next = MODE_ENC;
          3'd1: mode_next = MODE_DEC;
          3'd2: begin
            mode_next = (key_cnt_reg < KEY_HALF) ? MODE_KEY_LO : MODE_KEY_HI;
            if (key_cnt_reg == KEY_LAST) begin
              key_cnt_next    = '0;
              key_loaded_next = 1'b1;
            end else begin
              key_cnt_next = key_cnt_reg + 1'b1;
              // First word of a fresh load invalidates the previous key.
              if (key_cnt_reg == '0)
                key_loaded_next = 1'b0;
            end
          end
          3'd3: begin
            mode_next       = MODE_SRST;
            key_cnt_next    = '0;
            key_loaded_next = 1'b0;
          end
          default: mode_next = MODE_NONE;
        endcase
      end else if (PADDR == 3'd4) begin
        mode_next = MODE_POP;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      err_reg        <= 1'b0;
      mode_reg       <= MODE_NONE;
      wdata_reg      <= '0;
      key_cnt_reg    <= '0;
      key_loaded_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      err_reg        <= err_next;
      mode_reg       <= mode_next;
      wdata_reg      <= wdata_next;
      key_cnt_reg    <= key_cnt_next;
      key_loaded_reg <= key_loaded_next;
    end
  end

  assign mode       = mode_reg;
  assign wdata_out  = wdata_reg;
  assign key_loaded = key_loaded_reg;

endmodule

// File: tb/tb_apb_des_ctrl.sv
// Self-checking bench for apb_des_ctrl: directed scenarios plus random APB traffic
// compared against a transaction-level model of the register map.
module tb_apb_des_ctrl;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 5;
  localparam int IN_DEPTH  = 24;
  localparam int KEY_WORDS = 6;

  logic              clk;
  logic              n_rst;
  logic [2:0]        PADDR;
  logic              PSEL, PENABLE, PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY, PSLVERR;
  logic [CNT_W-1:0]  data_in_cnt, data_out_cnt;
  logic [DATA_W-1:0] data_out;
  logic [2:0]        mode;
  logic [DATA_W-1:0] wdata_out;
  logic              key_loaded;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_key_cnt;
  bit          m_loaded;
  logic [31:0] m_wdata;

  apb_des_ctrl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .IN_DEPTH(IN_DEPTH), .KEY_WORDS(KEY_WORDS)
  ) dut (
    .clk(clk), .n_rst(n_rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .data_in_cnt(data_in_cnt), .data_out_cnt(data_out_cnt),
    .data_out(data_out), .mode(mode), .wdata_out(wdata_out), .key_loaded(key_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key_cnt = 0;
    m_loaded  = 1'b0;
    m_wdata   = 32'h0;
  endtask

  // One complete APB transfer, checked against the model.
  task automatic apb(input bit wr, input logic [2:0] addr, input logic [31:0] wd,
                     input logic [4:0] din, input logic [4:0] dout,
                     input logic [31:0] dhead, input string tag);
    bit          err;
    int          exp_waits;
    logic [31:0] exp_rd;
    logic [2:0]  exp_mode;
    int          waits;
    bit          got;
    logic [31:0] rd;
    logic        se;
    logic [2:0]  m1, m2;
    logic [31:0] wo;
    logic        kl;

    if (wr)
      err = (addr >= 3'd4) || ((addr <= 3'd1) && ((int'(din) >= IN_DEPTH) || !m_loaded));
    else
      err = (addr < 3'd4) || ((addr == 3'd4) && (dout == 5'd0));
    exp_rd    = 32'h0;
    exp_mode  = 3'd0;
    exp_waits = (!wr && addr == 3'd4 && !err) ? 1 : 0;
    if (!err) begin
      if (wr) begin
        m_wdata = wd;
        case (addr)
          3'd0: exp_mode = 3'd1;
          3'd1: exp_mode = 3'd2;
          3'd2: begin
            exp_mode = (m_key_cnt < KEY_WORDS / 2) ? 3'd3 : 3'd4;
            if (m_key_cnt == 0) m_loaded = 1'b0;
            m_key_cnt++;
            if (m_key_cnt == KEY_WORDS) begin
              m_key_cnt = 0;
              m_loaded  = 1'b1;
            end
          end
          3'd3: begin
            exp_mode  = 3'd5;
            m_key_cnt = 0;
            m_loaded  = 1'b0;
          end
          default: exp_mode = 3'd0;
        endcase
      end else begin
        case (addr)
          3'd4: begin exp_rd = dhead; exp_mode = 3'd6; end
          3'd5: exp_rd = 32'(din);
          3'd6: exp_rd = 32'(dout);
          3'd7: exp_rd = 32'(m_key_cnt * 2 + int'(m_loaded));
          default: exp_rd = 32'h0;
        endcase
      end
    end

    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    data_in_cnt = din; data_out_cnt = dout; data_out = dhead;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0; got = 1'b0; rd = 32'h0; se = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (PREADY) begin
        rd = PRDATA; se = PSLVERR; got = 1'b1;
        break;
      end
      waits++;
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge clk);
    m1 = mode; wo = wdata_out; kl = key_loaded;
    @(negedge clk);
    m2 = mode;

    check({tag, " ready"},    32'(got), 32'd1);
    check({tag, " waits"},    32'(waits), 32'(exp_waits));
    check({tag, " slverr"},   32'(se), 32'(err));
    check({tag, " prdata"},   rd, exp_rd);
    check({tag, " mode"},     32'(m1), 32'(exp_mode));
    check({tag, " mode_end"}, 32'(m2), 32'd0);
    check({tag, " wdata"},    wo, m_wdata);
    check({tag, " key_ld"},   32'(kl), 32'(m_loaded));
    $display("xfer %-10s wr=%0d addr=%0d wd=%08h waits=%0d err=%0d rd=%08h mode=%0d key_loaded=%0d",
             tag, wr, addr, wd, waits, se, rd, m1, kl);
  endtask

  initial begin
    bit          wr;
    logic [2:0]  addr;
    logic [4:0]  din, dout;

    n_rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 3'd0;
    PWDATA = '0; data_in_cnt = '0; data_out_cnt = '0; data_out = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst pready",  32'(PREADY), 32'd0);
    check("rst pslverr", 32'(PSLVERR), 32'd0);
    check("rst prdata",  PRDATA, 32'h0);
    check("rst mode",    32'(mode), 32'd0);
    check("rst wdata",   wdata_out, 32'h0);
    check("rst key_ld",  32'(key_loaded), 32'd0);
    @(negedge clk); n_rst = 1'b1;

    // Encrypt before any key is loaded
    apb(1'b1, 3'd0, 32'h5555, 5'd3, 5'd0, 32'h0, "enc_nokey");

    // Full key load
    for (int i = 0; i < KEY_WORDS; i++)
      apb(1'b1, 3'd2, 32'hA + 32'(i), 5'd0, 5'd0, 32'h0, "key");
    apb(1'b0, 3'd7, 32'h0, 5'd0, 5'd0, 32'h0, "status");

    apb(1'b1, 3'd0, 32'h1234, 5'd3, 5'd0, 32'h0, "enc");
    apb(1'b1, 3'd0, 32'h9999, 5'd24, 5'd0, 32'h0, "enc_full");
    apb(1'b1, 3'd1, 32'h4321, 5'd23, 5'd0, 32'h0, "dec");
    apb(1'b0, 3'd4, 32'h0, 5'd0, 5'd2, 32'hCAFEF00D, "pop");
    apb(1'b0, 3'd4, 32'h0, 5'd0, 5'd0, 32'hCAFEF00D, "pop_empty");
    apb(1'b1, 3'd5, 32'h77, 5'd0, 5'd0, 32'h0, "wr_ro");
    apb(1'b0, 3'd1, 32'h0, 5'd0, 5'd0, 32'h0, "rd_wo");

    // Key load interleaved with a level read
    for (int i = 0; i < 3; i++)
      apb(1'b1, 3'd2, 32'h100 + 32'(i), 5'd0, 5'd0, 32'h0, "key_a");
    apb(1'b0, 3'd5, 32'h0, 5'd17, 5'd0, 32'h0, "lvl_in");
    for (int i = 0; i < 3; i++)
      apb(1'b1, 3'd2, 32'h200 + 32'(i), 5'd0, 5'd0, 32'h0, "key_b");

    // Aborted key write: PSEL drops in ACCESS
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd2; PWDATA = 32'hDEAD;
    @(posedge clk); #1;
    PSEL = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort mode", 32'(mode), 32'd0);
    $display("xfer abort      key write dropped in ACCESS mode=%0d", mode);
    apb(1'b0, 3'd7, 32'h0, 5'd0, 5'd0, 32'h0, "status2");

    apb(1'b1, 3'd3, 32'h5A5A, 5'd0, 5'd0, 32'h0, "soft_rst");
    apb(1'b0, 3'd7, 32'h0, 5'd0, 5'd0, 32'h0, "status3");

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 3'($urandom_range(0, 7));
      if (wr && ($urandom_range(0, 3) != 0)) addr = 3'($urandom_range(0, 2));
      if (wr && ($urandom_range(0, 9) == 0)) addr = 3'd3;
      if (!wr && ($urandom_range(0, 2) != 0)) addr = 3'($urandom_range(4, 7));
      din  = 5'($urandom_range(0, 31));
      dout = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      apb(wr, addr, $urandom, din, dout, $urandom, "rand");
    end

    // Reset asserted while in the read wait state
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 3'd4;
    data_out_cnt = 5'd2; data_out = 32'h13572468;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    check("rdwait pready", 32'(PREADY), 32'd0);
    #1 n_rst = 1'b0;
    #1;
    model_reset();
    check("mrst pready",  32'(PREADY), 32'd0);
    check("mrst pslverr", 32'(PSLVERR), 32'd0);
    check("mrst prdata",  PRDATA, 32'h0);
    check("mrst mode",    32'(mode), 32'd0);
    check("mrst wdata",   wdata_out, 32'h0);
    check("mrst key_ld",  32'(key_loaded), 32'd0);
    @(posedge clk);
    @(negedge clk); n_rst = 1'b1;
    // PSEL/PENABLE still high: without a fresh setup nothing may start
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("norestart pready", 32'(PREADY), 32'd0);
      check("norestart mode",   32'(mode), 32'd0);
    end
    $display("xfer reset_rdw  reset in wait state pready=%0d mode=%0d", PREADY, mode);
    PSEL = 1'b0; PENABLE = 1'b0;
    apb(1'b0, 3'd7, 32'h0, 5'd0, 5'd0, 32'h0, "status4");
    apb(1'b1, 3'd0, 32'h1, 5'd0, 5'd0, 32'h0, "enc_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_des_ctrl.md
APB_DES_CTRL -- requirements
Module: apb_des_ctrl

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning APB data and datapath word width.
REQ-002 The block SHALL have parameter CNT_W, default 5, meaning the width of the FIFO occupancy count inputs.
REQ-003 The block SHALL have parameter IN_DEPTH, default 24, meaning input FIFO capacity in words.
REQ-004 The block SHALL have parameter KEY_WORDS, default 6, meaning key words per full key load; it SHALL be even and at least 2.

Interface
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 n_rst  in  1  asynchronous, active-low reset.
REQ-007 PADDR  in  3  APB word address.
REQ-008 PSEL, PENABLE, PWRITE  in  1 each  APB select, enable and direction signals.
REQ-009 PWDATA  in  DATA_W  APB write data.
REQ-010 PRDATA  out  DATA_W  APB read data; 0 whenever not in ACCESS.
REQ-011 PREADY  out  1  APB ready; 1 only in state ACCESS.
REQ-012 PSLVERR  out  1  APB error; valid only when PREADY=1, otherwise 0.
REQ-013 data_in_cnt, data_out_cnt  in  CNT_W each  input and output FIFO occupancy.
REQ-014 data_out  in  DATA_W  output FIFO head word.
REQ-015 mode  out  3  one-cycle command pulse: 0 none, 1 enc push, 2 dec push, 3 key low half, 4 key high half, 5 soft reset, 6 output pop.
REQ-016 wdata_out  out  DATA_W  registered PWDATA of the last completed write.
REQ-017 key_loaded  out  1  1 once a full key of KEY_WORDS words is loaded.

Function
REQ-018 The address map SHALL be: 0 enc write, 1 dec write, 2 key write, 3 soft reset write, 4 data read, 5 read {0,data_in_cnt}, 6 read {0,data_out_cnt}, 7 status read {0,key_cnt,key_loaded}.
REQ-019 The FSM SHALL have three states, IDLE, RD_WAIT and ACCESS.
REQ-020 In IDLE, PSEL=1 with PENABLE=0 (setup) SHALL move the FSM to RD_WAIT for a valid, non-error read of address 4, and to ACCESS otherwise.
REQ-021 RD_WAIT SHALL insert exactly one wait state (PREADY=0) and then move to ACCESS.
REQ-022 ACCESS SHALL complete the transfer (PREADY=1) and return to IDLE.
REQ-023 PSEL=0 in RD_WAIT or ACCESS SHALL abort the transfer: return to IDLE with no side effect and no mode pulse.
REQ-024 The error flag SHALL be latched in the setup cycle and SHALL be set for any of: write to addresses 4-7; read of addresses 0-3; enc/dec write when data_in_cnt >= IN_DEPTH; enc/dec write when key_loaded=0; read of address 4 when data_out_cnt=0.
REQ-025 An errored transfer SHALL complete with zero wait states, PSLVERR=1 and PRDATA=0, and SHALL produce no mode pulse and no state change.
REQ-026 On a successful transfer completion (PSEL & PENABLE & PREADY), mode SHALL pulse with the command code in the next cycle only, and wdata_out SHALL capture PWDATA on writes.
REQ-027 In ACCESS, a successful address 4 read SHALL drive PRDATA=data_out, and mode=6 SHALL follow in the next cycle.
REQ-028 key_cnt (width clog2(KEY_WORDS)) SHALL increment on each key write.
REQ-029 A key write SHALL pulse mode=3 when key_cnt < KEY_WORDS/2, and mode=4 otherwise.
REQ-030 On the key write at key_cnt = KEY_WORDS-1, key_cnt SHALL wrap to 0 and key_loaded SHALL be set.
REQ-031 Other accesses during a key load SHALL be served normally, and key_cnt SHALL hold.
REQ-032 A new key load after key_loaded=1 SHALL clear key_loaded on its first word.
REQ-033 A soft reset write SHALL clear key_cnt and key_loaded and pulse mode=5.
REQ-034 Simultaneous events SHALL NOT occur, since only one APB transfer is in flight and at most one mode pulse is issued per transfer.

Reset
REQ-035 Asserting n_rst low SHALL immediately force state IDLE, mode=0, wdata_out=0, key_cnt=0, key_loaded=0, PREADY=0, PSLVERR=0 and PRDATA=0, including mid-transfer.
REQ-036 After reset, the first transfer SHALL require a fresh setup cycle.

Verification
REQ-037 Bench SHALL load 6 key writes 0xA..0xF -> mode 3,3,3,4,4,4, and key_loaded=1 after the 6th write; a status read (address 7) -> 0x1.
REQ-038 Bench SHALL issue an enc write 0x1234 with data_in_cnt=3 -> zero wait states, PSLVERR=0, then mode=1 for one cycle and wdata_out=0x1234.
REQ-039 Bench SHALL issue an enc write with data_in_cnt=24 -> PSLVERR=1 and mode stays 0; an enc write before any key load -> PSLVERR=1.
REQ-040 Bench SHALL issue an address 4 read with data_out_cnt=2 and data_out=0xCAFEF00D -> one wait state, PRDATA=0xCAFEF00D, then mode=6; the same read with data_out_cnt=0 -> PSLVERR=1, PRDATA=0.
REQ-041 Bench SHALL do 3 key writes, a read of address 5, then 3 more key writes -> key_loaded=1 after the 6th key write.
REQ-042 Bench SHALL drop n_rst in RD_WAIT -> IDLE, PREADY=0, and no mode=6 pulse.
